egg_timer_sequencer: RTL and testbench



---
 rtl/egg_timer_sequencer_if.sv | 34 +++
 rtl/egg_timer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_egg_timer_sequencer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/egg_timer_sequencer_if.sv
// egg_timer_sequencer_if: key/switch inputs and display outputs of the timer.
// SW, BTN_SET/START/CLEAR in; DIGITS, STATE, TICK, FLASH out.
interface egg_timer_sequencer_if;
  logic [7:0]  SW;
  logic        BTN_SET;
  logic        BTN_START;
  logic        BTN_CLEAR;
  logic [15:0] DIGITS;
  logic [2:0]  STATE;
  logic        TICK;
  logic        FLASH;

  modport master (
    output SW,
    output BTN_SET,
    output BTN_START,
    output BTN_CLEAR,
    input  DIGITS,
    input  STATE,
    input  TICK,
    input  FLASH
  );

  modport slave (
    input  SW,
    input  BTN_SET,
    input  BTN_START,
    input  BTN_CLEAR,
    output DIGITS,
    output STATE,
    output TICK,
    output FLASH
  );
endinterface

// File: rtl/egg_timer_sequencer.sv
// egg_timer_sequencer: MM:SS entry, BCD countdown and alarm flash control.
// Ports: CLOCK_50, RESET_N (async low), io (slave: SW/BTN_* in;
// DIGITS/STATE/TICK/FLASH out, all registered).
// Option: EGG_TIMER_PAUSE_EN adds START pause/resume while running.
module egg_timer_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FLASH_TICKS   = 12500000
) (
  input logic CLOCK_50,
  input logic RESET_N,
  egg_timer_sequencer_if.slave io
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int FW =
    (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TICKS_PER_SEC - 1);
  localparam logic [FW-1:0] F_LAST =
    FW'(FLASH_TICKS - 1);

  typedef enum logic [2:0] {
    SET_SEC   = 3'b000,
    SET_MIN   = 3'b001,
    RUN       = 3'b010,
    READY     = 3'b011,
    CLEAR     = 3'b100,
    FLASH_ON  = 3'b101,
    FLASH_OFF = 3'b110,
    PAUSED    = 3'b111
  } state_t;

  state_t        state, state_n;
  logic [15:0]   digits, digits_n;
  logic [15:0]   dec;
  logic [PW-1:0] presc, presc_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          tick, tick_n;
  logic          flash, flash_n;
  logic          pause_req;

  // Tens digit capped at 5, units at 9.
  function automatic logic [7:0] clamp(
    input logic [7:0] sw
  );
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (sw[7:4] > 4'd5) ? 4'd5 : sw[7:4];
    lo = (sw[3:0] > 4'd9) ? 4'd9 : sw[3:0];
    return {hi, lo};
  endfunction

  // One-second BCD decrement with borrow
  // chain; saturates at 00:00.
  function automatic logic [15:0] bcd_dec(
    input logic [15:0] d
  );
    logic [15:0] r;
    r = d;
    if (d == 16'h0000) begin
      r = d;
    end else if (d[3:0] != 4'd0) begin
      r[3:0] = d[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        r[7:4] = d[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (d[11:8] != 4'd0) begin
          r[11:8] = d[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = d[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

`ifdef EGG_TIMER_PAUSE_EN
  assign pause_req = io.BTN_START;
`else
  assign pause_req = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= CLEAR;
      digits <= '0;
      presc  <= '0;
      fcnt   <= '0;
      tick   <= 1'b0;
      flash  <= 1'b0;
    end else begin
      state  <= state_n;
      digits <= digits_n;
      presc  <= presc_n;
      fcnt   <= fcnt_n;
      tick   <= tick_n;
      flash  <= flash_n;
    end
  end

  always_comb begin
    state_n  = state;
    digits_n = digits;
    presc_n  = presc;
    fcnt_n   = fcnt;
    tick_n   = 1'b0;
    dec      = bcd_dec(digits);
    if (state == CLEAR) digits_n = '0;
    if (io.BTN_CLEAR) begin
      state_n = CLEAR;
    end else begin
      unique case (state)
        CLEAR: state_n = SET_SEC;
        SET_SEC: begin
          digits_n[7:0] = clamp(io.SW);
          if (io.BTN_SET) state_n = SET_MIN;
        end
        SET_MIN: begin
          digits_n[15:8] = clamp(io.SW);
          if (io.BTN_SET) state_n = READY;
        end
        READY: begin
          if (io.BTN_SET) begin
            state_n = SET_SEC;
          end else if (io.BTN_START &&
                       digits != 16'h0000) begin
            state_n = RUN;
            presc_n = '0;
          end
        end
        RUN: begin
          if (pause_req) begin
            state_n = PAUSED;
          end else if (presc == P_LAST) begin
            presc_n  = '0;
            tick_n   = 1'b1;
            digits_n = dec;
            // Last second expired: alarm
            // starts on the same edge.
            if (dec == 16'h0000) begin
              state_n = FLASH_ON;
              fcnt_n  = '0;
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        FLASH_ON, FLASH_OFF: begin
          if (io.BTN_SET || io.BTN_START) begin
            state_n = CLEAR;
          end else if (fcnt == F_LAST) begin
            fcnt_n  = '0;
            state_n = (state == FLASH_ON) ?
                      FLASH_OFF : FLASH_ON;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
`ifdef EGG_TIMER_PAUSE_EN
        PAUSED: begin
          if (io.BTN_START) state_n = RUN;
        end
`endif
        default: state_n = CLEAR;
      endcase
    end
    flash_n = (state_n == FLASH_ON);
  end

  assign io.DIGITS = digits;
  assign io.STATE  = state;
  assign io.TICK   = tick;
  assign io.FLASH  = flash;

endmodule

// File: tb/tb_egg_timer_sequencer.sv
// tb_egg_timer_sequencer: vector table, directed corner sequences and a
// randomized run against a seconds-based reference model.
module tb_egg_timer_sequencer;

  localparam int TPS = 4;
  localparam int FT  = 2;
`ifdef EGG_TIMER_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  localparam logic [2:0] S_SSEC = 3'b000;
  localparam logic [2:0] S_SMIN = 3'b001;
  localparam logic [2:0] S_RDY  = 3'b011;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_CLR  = 3'b100;
  localparam logic [2:0] S_FON  = 3'b101;
  localparam logic [2:0] S_FOFF = 3'b110;
  localparam logic [2:0] S_PAUS = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  egg_timer_sequencer_if bus ();

  egg_timer_sequencer #(
    .TICKS_PER_SEC(TPS),
    .FLASH_TICKS(FT)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .io(bus)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    int st;
    int mins;
    int secs;
    int presc;
    int fcnt;
    bit tick;
    bit flash;
  } model_t;

  model_t m;

  function automatic model_t m_reset();
    model_t r;
    r.st = S_CLR; r.mins = 0; r.secs = 0;
    r.presc = 0; r.fcnt = 0;
    r.tick = 1'b0; r.flash = 1'b0;
    return r;
  endfunction

  function automatic model_t m_step(
    input model_t q, input logic [7:0] sw,
    input logic s, input logic go, input logic c
  );
    model_t n;
    int t;
    int ent;
    int hi;
    int lo;
    n = q;
    n.tick = 1'b0;
    hi = int'(sw[7:4]);
    lo = int'(sw[3:0]);
    ent = 10 * (hi > 5 ? 5 : hi) + (lo > 9 ? 9 : lo);
    if (q.st == S_CLR) begin n.mins = 0; n.secs = 0; end
    if (c) n.st = S_CLR;
    else begin
      case (q.st)
        S_CLR: n.st = S_SSEC;
        S_SSEC: begin n.secs = ent; if (s) n.st = S_SMIN; end
        S_SMIN: begin n.mins = ent; if (s) n.st = S_RDY; end
        S_RDY: begin
          if (s) n.st = S_SSEC;
          else if (go && q.mins * 60 + q.secs > 0) begin
            n.st = S_RUN; n.presc = 0;
          end
        end
        S_RUN: begin
          if (PAUSE && go) n.st = S_PAUS;
          else begin
            n.presc = (q.presc + 1) % TPS;
            if (n.presc == 0) begin
              t = q.mins * 60 + q.secs - 1;
              n.mins = t / 60; n.secs = t % 60; n.tick = 1'b1;
              if (t == 0) begin n.st = S_FON; n.fcnt = 0; end
            end
          end
        end
        S_PAUS: if (go) n.st = S_RUN;
        S_FON, S_FOFF: begin
          if (s || go) n.st = S_CLR;
          else begin
            n.fcnt = (q.fcnt + 1) % FT;
            if (n.fcnt == 0) n.st = (q.st == S_FON) ? S_FOFF : S_FON;
          end
        end
        default: n.st = S_CLR;
      endcase
    end
    n.flash = (n.st == S_FON);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else m <= m_step(m, bus.SW, bus.BTN_SET, bus.BTN_START, bus.BTN_CLEAR);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] d,
                           input logic [2:0] st, input logic tk,
                           input logic fl);
    check({name, ".digits"}, 32'(bus.DIGITS), 32'(d));
    check({name, ".state"}, 32'(bus.STATE), 32'(st));
    check({name, ".tick"}, 32'(bus.TICK), 32'(tk));
    check({name, ".flash"}, 32'(bus.FLASH), 32'(fl));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic go, input logic c);
    bus.BTN_SET = s; bus.BTN_START = go; bus.BTN_CLEAR = c;
    step(1);
    bus.BTN_SET = 1'b0; bus.BTN_START = 1'b0; bus.BTN_CLEAR = 1'b0;
  endtask

  task automatic go_home();
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
  endtask

  task automatic load(input logic [7:0] mn, input logic [7:0] sc);
    bus.SW = sc; pulse(1'b1, 1'b0, 1'b0);
    bus.SW = mn; pulse(1'b1, 1'b0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  sw;
    logic [2:0]  btn;   // {clear, set, start}
    logic [15:0] d;
    logic [2:0]  st;
    logic        tk;
    logic        fl;
  } vec_t;

  vec_t vt[19];

  initial begin
    vt[0]  = '{8'hF7, 3'b000, 16'h0000, S_SSEC, 1'b0, 1'b0};
    vt[1]  = '{8'hF7, 3'b010, 16'h0057, S_SMIN, 1'b0, 1'b0};
    vt[2]  = '{8'h12, 3'b000, 16'h1257, S_SMIN, 1'b0, 1'b0};
    vt[3]  = '{8'h12, 3'b010, 16'h1257, S_RDY,  1'b0, 1'b0};
    vt[4]  = '{8'h00, 3'b001, 16'h1257, S_RUN,  1'b0, 1'b0};
    vt[5]  = '{8'h00, 3'b000, 16'h1257, S_RUN,  1'b0, 1'b0};
    vt[6]  = '{8'h00, 3'b000, 16'h1257, S_RUN,  1'b0, 1'b0};
    vt[7]  = '{8'h00, 3'b000, 16'h1257, S_RUN,  1'b0, 1'b0};
    vt[8]  = '{8'h00, 3'b000, 16'h1256, S_RUN,  1'b1, 1'b0};
    vt[9]  = '{8'h00, 3'b000, 16'h1256, S_RUN,  1'b0, 1'b0};
    vt[10] = '{8'h00, 3'b000, 16'h1256, S_RUN,  1'b0, 1'b0};
    vt[11] = '{8'h00, 3'b000, 16'h1256, S_RUN,  1'b0, 1'b0};
    vt[12] = '{8'h00, 3'b000, 16'h1255, S_RUN,  1'b1, 1'b0};
    vt[13] = '{8'h00, 3'b110, 16'h1255, S_CLR,  1'b0, 1'b0};
    vt[14] = '{8'h00, 3'b000, 16'h0000, S_SSEC, 1'b0, 1'b0};
    vt[15] = '{8'h00, 3'b010, 16'h0000, S_SMIN, 1'b0, 1'b0};
    vt[16] = '{8'h00, 3'b010, 16'h0000, S_RDY,  1'b0, 1'b0};
    vt[17] = '{8'h00, 3'b001, 16'h0000, S_RDY,  1'b0, 1'b0};
    vt[18] = '{8'h00, 3'b010, 16'h0000, S_SSEC, 1'b0, 1'b0};

    bus.SW = 8'h00;
    bus.BTN_SET = 1'b0; bus.BTN_START = 1'b0; bus.BTN_CLEAR = 1'b0;

    // reset state
    rst_n = 1'b0;
    step(3);
    check_out("reset", 16'h0000, S_CLR, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // entry, clamp, countdown, priority, zero-start
    for (int i = 0; i < 19; i++) begin
      bus.SW = vt[i].sw;
      bus.BTN_CLEAR = vt[i].btn[2];
      bus.BTN_SET = vt[i].btn[1];
      bus.BTN_START = vt[i].btn[0];
      step(1);
      check_out($sformatf("vec%0d", i), vt[i].d, vt[i].st, vt[i].tk, vt[i].fl);
    end
    bus.BTN_SET = 1'b0; bus.BTN_START = 1'b0; bus.BTN_CLEAR = 1'b0;

    // borrow chains
    load(8'h01, 8'h00);
    pulse(1'b0, 1'b1, 1'b0);
    step(4);
    check_out("borrow_0100", 16'h0059, S_RUN, 1'b1, 1'b0);
    go_home();
    load(8'h10, 8'h00);
    pulse(1'b0, 1'b1, 1'b0);
    step(4);
    check_out("borrow_1000", 16'h0959, S_RUN, 1'b1, 1'b0);

    // expiry and flash cadence
    go_home();
    load(8'h00, 8'h01);
    pulse(1'b0, 1'b1, 1'b0);
    step(4);
    check_out("expire", 16'h0000, S_FON, 1'b1, 1'b1);
    step(1);
    check_out("flash_on2", 16'h0000, S_FON, 1'b0, 1'b1);
    step(1);
    check_out("flash_off1", 16'h0000, S_FOFF, 1'b0, 1'b0);
    step(1);
    check_out("flash_off2", 16'h0000, S_FOFF, 1'b0, 1'b0);
    step(1);
    check_out("flash_on3", 16'h0000, S_FON, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    check_out("flash_ack", 16'h0000, S_CLR, 1'b0, 1'b0);
    step(1);
    check_out("after_ack", 16'h0000, S_SSEC, 1'b0, 1'b0);

    // async reset mid-run
    load(8'h00, 8'h05);
    pulse(1'b0, 1'b1, 1'b0);
    step(4);
    check_out("pre_reset", 16'h0004, S_RUN, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 16'h0000, S_CLR, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check_out("post_reset", 16'h0000, S_SSEC, 1'b0, 1'b0);

`ifdef EGG_TIMER_PAUSE_EN
    load(8'h00, 8'h05);
    pulse(1'b0, 1'b1, 1'b0);
    step(2);
    pulse(1'b0, 1'b1, 1'b0);
    check_out("pause", 16'h0005, S_PAUS, 1'b0, 1'b0);
    step(10);
    check_out("paused_hold", 16'h0005, S_PAUS, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check_out("resume", 16'h0005, S_RUN, 1'b0, 1'b0);
    step(1);
    check_out("resume1", 16'h0005, S_RUN, 1'b0, 1'b0);
    step(1);
    check_out("resume_tick", 16'h0004, S_RUN, 1'b1, 1'b0);
`endif

    // randomized run against the model
    @(negedge clk);
    rst_n = 1'b0;
    bus.SW = 8'h00;
    bus.BTN_SET = 1'b0; bus.BTN_START = 1'b0; bus.BTN_CLEAR = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 0) bus.SW = 8'($urandom_range(0, 2));
      else bus.SW = 8'($urandom);
      bus.BTN_CLEAR = ($urandom_range(0, 127) == 0);
      bus.BTN_SET = ($urandom_range(0, 7) == 0);
      bus.BTN_START = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      check($sformatf("rand%0d", i),
            {bus.DIGITS, 5'd0, bus.STATE, 6'd0, bus.TICK, bus.FLASH},
            {4'(m.mins / 10), 4'(m.mins % 10),
             4'(m.secs / 10), 4'(m.secs % 10),
             5'd0, 3'(m.st), 6'd0, m.tick, m.flash});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
